regfile_wb_queue: RTL and testbench

// Write-side initiator for the regfile write port (we3/wa3/wd3). Buffers writeback

---
 rtl/regfile_wb_queue.sv | 135 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - writeback queue feeding the regfile write port (we3/wa3/wd3)
// Optional forwarding lookup of queued writes is enabled by defining WBQ_FWD_EN.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AW-1:0]              req_addr,
  input  logic [DW-1:0]              req_data,
  input  logic                       drain_en,
  output logic                       we3,
  output logic [AW-1:0]              wa3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              la1,
  input  logic [AW-1:0]              la2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          accept, push, pop;

  // Writes to $0 are handshaked like any other request but never stored.
  assign req_ready = (count_q != FULL);
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_addr != '0);
  assign pop       = (count_q != '0) && drain_en;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      we3_d    = 1'b1;
      wa3_d    = mem_addr_q[rd_ptr_q];
      wd3_d    = mem_data_q[rd_ptr_q];
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= req_addr;
      mem_data_q[wr_ptr_q] <= req_data;
    end
  end

  assign we3   = we3_q;
  assign wa3   = wa3_q;
  assign wd3   = wd3_q;
  assign count = count_q;

`ifdef WBQ_FWD_EN
  // Scan output stage first, then queue oldest to newest, so the youngest match wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] la);
    logic          h;
    logic [DW-1:0] d;
    logic [PW-1:0] idx;
    h = 1'b0;
    d = '0;
    if (we3_q && (wa3_q == la)) begin
      h = 1'b1;
      d = wd3_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_addr_q[idx] == la)) begin
        h = 1'b1;
        d = mem_data_q[idx];
      end
    end
    if (la == '0) begin
      h = 1'b0;
      d = '0;
    end
    return {h, d};
  endfunction

  assign {hit1, fwd1} = lookup(la1);
  assign {hit2, fwd2} = lookup(la2);
`else
  logic unused_la;
  assign unused_la = ^{la1, la2};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign fwd1 = '0;
  assign fwd2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - self-checking bench for regfile_wb_queue against a queue model
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          drain_en;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] la1, la2;
  logic          hit1, hit2;
  logic [DW-1:0] fwd1, fwd2;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .drain_en(drain_en),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .la1(la1), .la2(la2),
    .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending writes plus the last issued write.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           mq[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      bit had_room;
      wr_t w;
      had_room = (mq.size() < DEPTH);
      if (mq.size() > 0 && drain_en) begin
        w = mq.pop_front();
        m_we = 1'b1; m_wa = w.a; m_wd = w.d;
      end else begin
        m_we = 1'b0;
      end
      if (req_valid && had_room && req_addr != 0) begin
        w.a = req_addr; w.d = req_data;
        mq.push_back(w);
      end
    end
  end

  function automatic logic [DW:0] m_lookup(input logic [AW-1:0] la);
`ifdef WBQ_FWD_EN
    if (la == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == la) return {1'b1, mq[i].d};
    if (m_we && m_wa == la) return {1'b1, m_wd};
    return '0;
`else
    return (la == la) ? '0 : '0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic [DW:0] e1, e2;
      e1 = m_lookup(la1);
      e2 = m_lookup(la2);
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
      chk("m_we3", 64'(we3), 64'(m_we));
      chk("m_wa3", 64'(wa3), 64'(m_wa));
      chk("m_wd3", 64'(wd3), 64'(m_wd));
      chk("m_hit1", 64'(hit1), 64'(e1[DW]));
      chk("m_fwd1", 64'(fwd1), 64'(e1[DW-1:0]));
      chk("m_hit2", 64'(hit2), 64'(e2[DW]));
      chk("m_fwd2", 64'(fwd2), 64'(e2[DW-1:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v; req_addr = a; req_data = d;
  endtask

  initial begin
    reset = 1'b1; drain_en = 1'b0; la1 = '0; la2 = '0;
    drive(1'b0, '0, '0);
    step();
    started = 1'b1;
    step();
    chk("rst_count", 64'(count), 0);
    chk("rst_ready", 64'(req_ready), 1);
    chk("rst_we3", 64'(we3), 0);

    // single write, one-cycle issue latency
    reset = 1'b0; drain_en = 1'b1;
    drive(1'b1, 5'd2, 32'hDEADBEEF);
    step();
    drive(1'b0, '0, '0);
    step();
    chk("t1_we3", 64'(we3), 1);
    chk("t1_wa3", 64'(wa3), 2);
    chk("t1_wd3", 64'(wd3), 64'hDEADBEEF);
    step();
    chk("t1_we3_low", 64'(we3), 0);

    // fill while held off, then drain in order
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), DW'(32'h100 + i));
      step();
    end
    drive(1'b0, '0, '0);
    chk("t2_full_count", 64'(count), 4);
    chk("t2_full_ready", 64'(req_ready), 0);
    drive(1'b1, 5'd5, 32'h105);
    step();
    drive(1'b0, '0, '0);
    chk("t2_held_count", 64'(count), 4);
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_drain_wa3", 64'(wa3), 64'(i));
      chk("t2_drain_wd3", 64'(wd3), 64'(32'h100 + i));
      chk("t2_drain_count", 64'(count), 64'(4 - i));
    end
    step();
    chk("t2_idle_we3", 64'(we3), 0);

    // $0 writes are swallowed
    drive(1'b1, 5'd0, 32'h12345678);
    step();
    drive(1'b0, '0, '0);
    chk("t3_count", 64'(count), 0);
    step();
    chk("t3_we3", 64'(we3), 0);

    // repeated writes to r5: youngest wins on lookup
    drain_en = 1'b0;
    drive(1'b1, 5'd5, 32'h11); step();
    drive(1'b1, 5'd5, 32'h22); step();
    drive(1'b0, '0, '0);
    la1 = 5'd5; la2 = 5'd6;
    #1;
`ifdef WBQ_FWD_EN
    chk("t4_hit1", 64'(hit1), 1);
    chk("t4_fwd1", 64'(fwd1), 64'h22);
`else
    chk("t4_hit1", 64'(hit1), 0);
    chk("t4_fwd1", 64'(fwd1), 0);
`endif
    chk("t4_hit2", 64'(hit2), 0);
    drain_en = 1'b1;
    step();
    chk("t4_first_wd3", 64'(wd3), 64'h11);
    step();
    chk("t4_second_wd3", 64'(wd3), 64'h22);
    step();
    la1 = '0; la2 = '0;

    // steady push+pop at count=2 across pointer wrap
    drain_en = 1'b0;
    drive(1'b1, 5'd7, 32'h70); step();
    drive(1'b1, 5'd8, 32'h80); step();
    drain_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, AW'(9 + k), DW'(32'h90 + k));
      step();
      chk("t5_count", 64'(count), 2);
      chk("t5_wa3", 64'(wa3), (k == 0) ? 64'd7 : (k == 1) ? 64'd8 : 64'(9 + k - 2));
    end
    drive(1'b0, '0, '0);
    repeat (3) step();

    // reset drops pending entries
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(20 + i), DW'(32'hA0 + i));
      step();
    end
    drive(1'b0, '0, '0);
    chk("t6_pre_count", 64'(count), 3);
    reset = 1'b1; drain_en = 1'b1;
    step();
    chk("t6_count", 64'(count), 0);
    chk("t6_we3", 64'(we3), 0);
    chk("t6_ready", 64'(req_ready), 1);
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("t6_no_write", 64'(we3), 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
